// File: rtl/spi_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_sequencer
// Description : Byte-level command controller between an SPI slave shifter
//               and a small bank of 8-bit control registers. Each chip-select
//               frame is a command byte (bit 7 = read, bits 6:0 = address)
//               followed by data bytes, with address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_sequencer #(
  parameter int         NREG      = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [8*NREG-1:0] regs,
  output logic              led,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CMD   = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_READ  = 2'd3;

  // Register count as an 8-bit value so it can be compared against a
  // zero-extended 7-bit address (NREG may be 128).
  localparam logic [7:0] c_NREG8 = 8'(NREG);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_cs_prev;
  logic [6:0]           r_addr;
  logic [NREG-1:0][7:0] r_regs;
  logic [7:0]           r_tx_byte;
  logic                 r_tx_load;
  logic                 r_err;

  logic                 w_cs_rise;
  logic [6:0]           w_addr_inc;
  logic                 w_wr_ok;
  logic [6:0]           w_rd_addr;
  logic                 w_rd_ok;
  logic [7:0]           w_rd_data;
  logic                 w_busy;

  assign w_cs_rise  = cs_active & ~r_cs_prev;
  assign w_addr_inc = r_addr + 7'd1;
  assign w_wr_ok    = {1'b0, r_addr} < c_NREG8;

  // Chip-select history for edge detection. Resets to 1 so that a chip
  // select already held high when reset releases does not start a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_prev <= cs_active;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a byte arriving together with chip-select release is
  // still consumed by the datapath, the FSM simply returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_cs_rise) begin
          w_state_next = c_CMD;
        end
      end
      c_CMD: begin
        if (!cs_active) begin
          w_state_next = c_IDLE;
        end else if (rx_valid) begin
          w_state_next = rx_byte[7] ? c_READ : c_WRITE;
        end
      end
      c_WRITE, c_READ: begin
        if (!cs_active) begin
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    w_busy = (r_state != c_IDLE);
  end

  // Read-reply mux: in CMD the address comes straight from the command
  // byte, in READ it is the next sequential address. Unmapped reads 8'hFF.
  always_comb begin
    w_rd_addr = (r_state == c_CMD) ? rx_byte[6:0] : w_addr_inc;
    w_rd_ok   = {1'b0, w_rd_addr} < c_NREG8;
    w_rd_data = 8'hFF;
    for (int i = 0; i < NREG; i++) begin
      if (w_rd_addr == 7'(i)) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  // Datapath: register bank, address pointer, reply byte and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= 7'd0;
      r_regs    <= '0;
      r_tx_byte <= 8'h00;
      r_tx_load <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_cs_rise) begin
            r_err     <= 1'b0;
            r_tx_byte <= SYNC_BYTE;
            r_tx_load <= 1'b1;
          end
        end
        c_CMD: begin
          if (rx_valid) begin
            r_addr <= rx_byte[6:0];
            if (rx_byte[7]) begin
              r_tx_byte <= w_rd_data;
              r_tx_load <= 1'b1;
              if (!w_rd_ok) begin
                r_err <= 1'b1;
              end
            end
          end
        end
        c_WRITE: begin
          if (rx_valid) begin
            if (w_wr_ok) begin
              for (int i = 0; i < NREG; i++) begin
                if (r_addr == 7'(i)) begin
                  r_regs[i] <= rx_byte;
                end
              end
            end else begin
              r_err <= 1'b1;
            end
            r_addr <= w_addr_inc;
          end
        end
        c_READ: begin
          if (rx_valid) begin
            r_addr    <= w_addr_inc;
            r_tx_byte <= w_rd_data;
            r_tx_load <= 1'b1;
            if (!w_rd_ok) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_tx_load <= 1'b0;
        end
      endcase
    end
  end

  assign regs    = r_regs;
  assign led     = r_regs[0][0];
  assign tx_byte = r_tx_byte;
  assign tx_load = r_tx_load;
  assign busy    = w_busy;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_sequencer
// Description : Directed self-checking bench for spi_reg_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_sequencer;

  localparam int NREG = 4;

  logic              clk;
  logic              reset_n;
  logic              cs_active;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              tx_load;
  logic [8*NREG-1:0] regs;
  logic              led;
  logic              busy;
  logic              err;

  int n_checks;
  int n_pass;
  int n_dbl;
  logic r_prev_load;
  logic [7:0] tx_q[$];

  spi_reg_sequencer #(.NREG(NREG), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs_active(cs_active),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load),
    .regs     (regs),
    .led      (led),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every reply byte and count back-to-back load pulses.
  initial r_prev_load = 1'b0;
  always @(negedge clk) begin
    if (tx_load === 1'b1) tx_q.push_back(tx_byte);
    if (tx_load === 1'b1 && r_prev_load === 1'b1) n_dbl++;
    r_prev_load = tx_load;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    cs_active = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(3);
  endtask

  task automatic end_frame();
    cs_active = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    n_checks++; if (regs !== '0) $display("FAIL reset_regs: got %h want 0", regs); else n_pass++;
    n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_byte); else n_pass++;
    n_checks++; if ({tx_load, led, busy, err} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {tx_load, led, busy, err}); else n_pass++;
    // Reset asserted in the middle of a frame
    start_frame();
    send_byte(8'h00);
    send_byte(8'h03);
    n_checks++; if (led !== 1'b1) $display("FAIL pre_reset_led: got %b want 1", led); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (regs !== '0) $display("FAIL midreset_regs: got %h want 0", regs); else n_pass++;
    n_checks++; if ({tx_load, led, busy, err} !== 4'b0000) $display("FAIL midreset_flags: got %b want 0000", {tx_load, led, busy, err}); else n_pass++;
    tick(2);
    tx_q.delete();
    reset_n = 1'b1;
    tick(5);
    n_checks++; if (tx_q.size() !== 0) $display("FAIL reset_cs_held_load: got %0d loads want 0", tx_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_cs_held_busy: got %b want 0", busy); else n_pass++;
    end_frame();
  endtask

  task automatic test_single_write();
    tx_q.delete();
    cs_active = 1'b1;
    tick(1);
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy); else n_pass++;
    tick(3);
    send_byte(8'h00);
    send_byte(8'h01);
    end_frame();
    n_checks++; if (tx_q.size() !== 1) $display("FAIL wr_load_count: got %0d want 1", tx_q.size());
    else if (tx_q[0] !== 8'hA5) $display("FAIL wr_sync_byte: got %h want a5", tx_q[0]);
    else n_pass++;
    n_checks++; if (regs[7:0] !== 8'h01) $display("FAIL wr_reg0: got %h want 01", regs[7:0]); else n_pass++;
    n_checks++; if (led !== 1'b1) $display("FAIL wr_led_on: got %b want 1", led); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL wr_err: got %b want 0", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", busy); else n_pass++;
    start_frame();
    send_byte(8'h00);
    send_byte(8'h00);
    end_frame();
    n_checks++; if (led !== 1'b0) $display("FAIL wr_led_off: got %b want 0", led); else n_pass++;
  endtask

  task automatic test_burst_write();
    start_frame();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_frame();
    n_checks++; if (regs !== 32'h2211_0000) $display("FAIL burst_regs: got %h want 22110000", regs); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL burst_err: got %b want 1", err); else n_pass++;
    cs_active = 1'b1;
    tick(2);
    n_checks++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else n_pass++;
    end_frame();
  endtask

  task automatic test_burst_read();
    logic [7:0] exp [5];
    exp[0] = 8'hA5; exp[1] = 8'h20; exp[2] = 8'h30; exp[3] = 8'h40; exp[4] = 8'hFF;
    start_frame();
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    end_frame();
    n_checks++; if (regs !== 32'h4030_2010) $display("FAIL preload_regs: got %h want 40302010", regs); else n_pass++;
    tx_q.delete();
    start_frame();
    send_byte(8'h81);
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'h5A);
    n_checks++; if (err !== 1'b1) $display("FAIL read_err: got %b want 1", err); else n_pass++;
    end_frame();
    n_checks++; if (tx_q.size() !== 5) $display("FAIL read_count: got %0d want 5", tx_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < tx_q.size()) begin
        n_checks++;
        if (tx_q[i] !== exp[i]) $display("FAIL read_byte%0d: got %h want %h", i, tx_q[i], exp[i]); else n_pass++;
      end
    end
    n_checks++; if (regs !== 32'h4030_2010) $display("FAIL read_no_side_effect: got %h want 40302010", regs); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    start_frame();
    send_byte(8'h7F);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_frame();
    n_checks++; if (regs !== 32'h4030_20BB) $display("FAIL wrap_regs: got %h want 403020bb", regs); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL wrap_err: got %b want 1", err); else n_pass++;
    n_checks++; if (led !== 1'b1) $display("FAIL wrap_led: got %b want 1", led); else n_pass++;
  endtask

  task automatic test_abort_coincidence();
    int n_before;
    start_frame();
    send_byte(8'h00);
    send_byte(8'h55);
    rx_byte   = 8'h66;
    rx_valid  = 1'b1;
    cs_active = 1'b0;
    tick(1);
    rx_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got busy %b want 0", busy); else n_pass++;
    n_checks++; if (regs[15:0] !== 16'h6655) $display("FAIL abort_regs: got %h want 6655", regs[15:0]); else n_pass++;
    tick(2);
    n_before = tx_q.size();
    send_byte(8'h77);
    n_checks++; if (regs !== 32'h4030_6655) $display("FAIL idle_rx_regs: got %h want 40306655", regs); else n_pass++;
    n_checks++; if (tx_q.size() !== n_before) $display("FAIL idle_rx_load: got %0d want %0d", tx_q.size(), n_before); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_rx_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_load_pulse();
    n_checks++; if (n_dbl !== 0) $display("FAIL tx_load_width: got %0d double pulses want 0", n_dbl); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_dbl     = 0;
    reset_n   = 1'b0;
    cs_active = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_addr_wrap();
    test_abort_coincidence();
    test_load_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
